// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, legality check and FSM encoding shared by the ALU, its decoder and alu_arbiter
// Ports: none (package)
package alu_pkg;
    localparam logic [3:0] OP_0000 = 4'b0000;
    localparam logic [3:0] OP_0001 = 4'b0001;
    localparam logic [3:0] OP_0010 = 4'b0010;
    localparam logic [3:0] OP_0011 = 4'b0011;
    localparam logic [3:0] OP_0100 = 4'b0100;
    localparam logic [3:0] OP_0101 = 4'b0101;
    localparam logic [3:0] OP_0110 = 4'b0110;
    localparam logic [3:0] OP_1000 = 4'b1000;
    localparam logic [3:0] OP_1001 = 4'b1001;
    localparam logic [3:0] OP_1010 = 4'b1010;
    localparam logic [3:0] OP_1011 = 4'b1011;
    localparam logic [3:0] OP_1100 = 4'b1100;
    localparam logic [3:0] OP_1101 = 4'b1101;
    localparam logic [3:0] OP_1110 = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // 0111 and 1111 are the only illegal codes
    function automatic logic is_legal_op(input logic [3:0] op);
        return op[2:0] != 3'b111;
    endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin grant
// Ports: valid[1:0] requests, last_grant index of the previous winner, grant[1:0] one-hot winner
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);
    // on a tie the requester that did not win last time gets the grant
    assign grant[0] = valid[0] & (~valid[1] | last_grant);
    assign grant[1] = valid[1] & (~valid[0] | ~last_grant);
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready requesters with round-robin grant
// Ports: clk, reset (sync, active-high); rN_req_valid/rN_req_ready/rN_op/rN_a/rN_b request channel;
//        rN_rsp_valid/rN_rsp_ready response channel; rsp_data/rsp_err shared result;
//        alu_a/alu_b/alu_op registered ALU inputs, alu_result ALU output; busy when not IDLE
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             r0_req_valid,
    output logic             r0_req_ready,
    input  logic [3:0]       r0_op,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    output logic             r0_rsp_valid,
    input  logic             r0_rsp_ready,
    input  logic             r1_req_valid,
    output logic             r1_req_ready,
    input  logic [3:0]       r1_op,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    output logic             r1_rsp_valid,
    input  logic             r1_rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy
);
    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       last_grant, owner;
    logic [1:0] grant;
    logic       sel, hs, legal, ack;
    logic [3:0] op_in;

    rr_arb2 u_arb (
        .valid      ({r1_req_valid, r0_req_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign sel   = grant[1];
    assign op_in = sel ? r1_op : r0_op;
    assign hs    = (state == ST_IDLE) && (grant != 2'b00);
    assign legal = is_legal_op(op_in);
    // only the owner's ready can release the response
    assign ack   = owner ? r1_rsp_ready : r0_rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (hs) state_nxt = legal ? ST_EXEC : ST_RESP;
            ST_EXEC: if (cnt == 4'd0) state_nxt = ST_RESP;
            ST_RESP: if (ack) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        r0_req_ready = hs & ~sel;
        r1_req_ready = hs & sel;
        r0_rsp_valid = (state == ST_RESP) & ~owner;
        r1_rsp_valid = (state == ST_RESP) & owner;
        busy         = state != ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            cnt        <= 4'd0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= 4'b0000;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (hs) begin
                last_grant <= sel;
                owner      <= sel;
                cnt        <= CNT_INIT;
                // an illegal op never reaches the ALU, so its inputs keep the previous operation
                if (legal) begin
                    alu_a  <= sel ? r1_a : r0_a;
                    alu_b  <= sel ? r1_b : r0_b;
                    alu_op <= op_in;
                end else begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
                end
            end
            if (state == ST_EXEC) begin
                if (cnt == 4'd0) begin
                    rsp_data <= alu_result;
                    rsp_err  <= 1'b0;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a transaction-level model
module tb_alu_arbiter;
    localparam int W  = 32;
    localparam int EC = 1;

    logic clk = 1'b0;
    logic reset, rst4;
    logic r0_req_valid, r0_req_ready, r0_rsp_valid, r0_rsp_ready;
    logic r1_req_valid, r1_req_ready, r1_rsp_valid, r1_rsp_ready;
    logic [3:0] r0_op, r1_op, alu_op;
    logic [W-1:0] r0_a, r0_b, r1_a, r1_b, rsp_data, alu_a, alu_b, alu_result;
    logic rsp_err, busy;

    logic q0_valid, q0_ready, q0_rsp_valid, q0_rsp_ready;
    logic q1_ready, q1_rsp_valid;
    logic [3:0] q0_op, q_alu_op;
    logic [W-1:0] q0_a, q0_b, q_rsp_data, q_alu_a, q_alu_b, q_alu_result;
    logic q_rsp_err, q_busy;

    int total = 0;
    int bad = 0;

    bit           have [2];
    logic [3:0]   op_q [2];
    logic [W-1:0] a_q  [2];
    logic [W-1:0] b_q  [2];
    int           last_g;
    logic [3:0]   last_op;
    logic [W-1:0] last_a;

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        return op == 4'd0 ? a + b : op == 4'd1 ? a - b : a;
    endfunction

    assign alu_result   = ref_alu(alu_op, alu_a, alu_b);
    assign q_alu_result = ref_alu(q_alu_op, q_alu_a, q_alu_b);

    alu_arbiter #(.WIDTH(W), .EXEC_CYCLES(EC)) dut (
        .clk(clk), .reset(reset),
        .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
        .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .busy(busy)
    );

    alu_arbiter #(.WIDTH(W), .EXEC_CYCLES(4)) dut4 (
        .clk(clk), .reset(rst4),
        .r0_req_valid(q0_valid), .r0_req_ready(q0_ready), .r0_op(q0_op), .r0_a(q0_a), .r0_b(q0_b),
        .r0_rsp_valid(q0_rsp_valid), .r0_rsp_ready(q0_rsp_ready),
        .r1_req_valid(1'b0), .r1_req_ready(q1_ready), .r1_op(4'd0), .r1_a('0), .r1_b('0),
        .r1_rsp_valid(q1_rsp_valid), .r1_rsp_ready(1'b0),
        .rsp_data(q_rsp_data), .rsp_err(q_rsp_err), .alu_a(q_alu_a), .alu_b(q_alu_b), .alu_op(q_alu_op),
        .alu_result(q_alu_result), .busy(q_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req;
        r0_req_valid = have[0]; r0_op = op_q[0]; r0_a = a_q[0]; r0_b = b_q[0];
        r1_req_valid = have[1]; r1_op = op_q[1]; r1_a = a_q[1]; r1_b = b_q[1];
    endtask

    task automatic fill(input int i, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        op_q[i] = op; a_q[i] = a; b_q[i] = b;
    endtask

    task automatic fill_rand(input int i);
        fill(i, $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1)), $urandom, $urandom);
    endtask

    task automatic set_rsp_rdy(input int w, input logic own, input logic oth);
        r0_rsp_ready = w == 0 ? own : oth;
        r1_rsp_ready = w == 1 ? own : oth;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        have[0] = 0; have[1] = 0;
        drive_req();
        set_rsp_rdy(0, 1'b0, 1'b0);
        repeat (2) tick();
        reset = 1'b0;
        last_g = 1; last_op = 4'd0; last_a = '0;
        #1;
        chk("rst_v0", r0_rsp_valid, 1'b0);
        chk("rst_v1", r1_rsp_valid, 1'b0);
        chk("rst_data", rsp_data, 0);
        chk("rst_err", rsp_err, 1'b0);
        chk("rst_alu", {alu_op, alu_a, alu_b}, 0);
        chk("rst_busy", busy, 1'b0);
    endtask

    // one transaction from IDLE: arbitration, latency, result, backpressure, release
    task automatic serve(input int bp, input bit poke, input bit late, output int gw);
        int w, o, n;
        bit legal;
        logic [W-1:0] ed;
        w = (have[0] && have[1]) ? (last_g == 1 ? 0 : 1) : (have[0] ? 0 : 1);
        o = 1 - w;
        legal = op_q[w][2:0] != 3'b111;
        ed = legal ? ref_alu(op_q[w], a_q[w], b_q[w]) : '0;
        if (legal) begin last_op = op_q[w]; last_a = a_q[w]; end
        drive_req();
        set_rsp_rdy(w, bp == 0, 1'b0);
        #1;
        chk("grant0", r0_req_ready, w == 0);
        chk("grant1", r1_req_ready, w == 1);
        gw = r1_req_ready ? 1 : 0;
        tick();
        last_g = w;
        have[w] = 0;
        if (late && !have[o]) have[o] = 1;
        drive_req();
        n = 1;
        #1;
        while (!(w == 1 ? r1_rsp_valid : r0_rsp_valid) && n < 40) begin
            tick();
            n++;
        end
        chk("latency", n, legal ? EC + 1 : 1);
        chk("rsp_data", rsp_data, ed);
        chk("rsp_err", rsp_err, !legal);
        chk("other_rsp_v", w == 1 ? r0_rsp_valid : r1_rsp_valid, 1'b0);
        chk("alu_op", alu_op, last_op);
        chk("alu_a", alu_a, last_a);
        for (int k = 0; k < bp; k++) begin
            set_rsp_rdy(w, 1'b0, poke);
            tick();
            chk("bp_valid", w == 1 ? r1_rsp_valid : r0_rsp_valid, 1'b1);
            chk("bp_data", {rsp_err, rsp_data}, {!legal, ed});
            chk("bp_rdy", r0_req_ready | r1_req_ready, 1'b0);
        end
        set_rsp_rdy(w, 1'b1, 1'b0);
        tick();
        set_rsp_rdy(w, 1'b0, 1'b0);
        #1;
        chk("rel_busy", busy, 1'b0);
        chk("rel_valid", r0_rsp_valid | r1_rsp_valid, 1'b0);
    endtask

    initial begin
        int gw, n;
        bit seen;
        q0_valid = 0; q0_op = 0; q0_a = 0; q0_b = 0; q0_rsp_ready = 0; rst4 = 1'b1;
        for (int i = 0; i < 2; i++) fill(i, 4'd0, '0, '0);
        do_reset();

        // single legal op, ready held high
        fill(0, 4'd0, 35, 12); have[0] = 1;
        serve(0, 0, 0, gw);
        chk("t1_owner", gw, 0);

        // tie from reset, then continuous contention
        do_reset();
        fill(0, 4'd0, 30, 20); have[0] = 1;
        fill(1, 4'd1, 50, 10); have[1] = 1;
        serve(0, 0, 0, gw); chk("t2_first", gw, 0);
        serve(0, 0, 0, gw); chk("t2_second", gw, 1);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 2; i++) if (!have[i]) begin fill_rand(i); have[i] = 1; end
            serve(1, 0, 0, gw);
            chk("t2_order", gw, k % 2);
        end

        // backpressure with r0 requesting meanwhile; r0's request is the illegal op that follows
        have[0] = 0; have[1] = 0;
        fill(1, 4'd0, 5, 5); have[1] = 1;
        fill(0, 4'd7, 1, 5);
        serve(6, 0, 1, gw);
        chk("t3_owner", gw, 1);
        serve(2, 0, 0, gw);
        chk("t4_owner", gw, 0);

        // r1 ready while r0 owns the response
        fill(0, 4'd1, 99, 9); have[0] = 1;
        serve(3, 1, 0, gw);

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 2; i++) if (!have[i]) begin
                fill_rand(i);
                have[i] = $urandom_range(0, 2) != 0;
            end
            if (!have[0] && !have[1]) have[$urandom_range(0, 1)] = 1;
            if (!have[0]) fill_rand(0);
            if (!have[1]) fill_rand(1);
            serve($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), gw);
        end

        // reset mid-execution on the EXEC_CYCLES=4 instance
        rst4 = 1'b1;
        repeat (2) tick();
        rst4 = 1'b0;
        q0_valid = 1; q0_op = 4'd0; q0_a = 12; q0_b = 40;
        #1;
        chk("t5_rdy", q0_ready, 1'b1);
        tick();
        q0_valid = 0;
        chk("t5_busy", q_busy, 1'b1);
        tick();
        rst4 = 1'b1;
        chk("t5_noval", q0_rsp_valid, 1'b0);
        tick();
        rst4 = 1'b0;
        chk("t5_busy_rst", q_busy, 1'b0);
        chk("t5_alu_a_rst", q_alu_a, 0);
        seen = q0_rsp_valid;
        repeat (10) begin tick(); seen |= q0_rsp_valid; end
        chk("t5_no_rsp", seen, 1'b0);
        q0_valid = 1; q0_op = 4'd0; q0_a = 7; q0_b = 8; q0_rsp_ready = 1;
        #1;
        chk("t5_rdy2", q0_ready, 1'b1);
        tick();
        q0_valid = 0;
        n = 1;
        while (!q0_rsp_valid && n < 40) begin tick(); n++; end
        chk("t5_latency", n, 5);
        chk("t5_data", q_rsp_data, 15);
        tick();
        chk("t5_done", q_busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
